calc_seq_ctrl: RTL and testbench

- Sequencing controller between the debounced keypad/equal inputs and a shared multi-cycle arithmetic unit in the calculator datapath.
- Assembles decimal operands from keypad digit codes and latches the operator.
- Issues a start/done handshake to the arithmetic unit and holds the result.
- Drives the value and error flag consumed by the seven-segment display driver.

---
 rtl/calc_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing controller: builds operands from keypad digits, runs the ALU start/done handshake, drives the display.
// Optional macro CALC_CHAIN_EN: an operator key in SHOW chains the result into operand A.
module calc_seq_ctrl #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_DIGITS  = 4,
  parameter int unsigned ALU_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_en,
  input  logic [3:0]        key_code,
  input  logic              equal,
  output logic              alu_start,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_err,
  output logic [DATA_W-1:0] disp_val,
  output logic              disp_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TMO_W = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_ENTER_A, ST_ENTER_B, ST_ISSUE, ST_WAIT, ST_SHOW, ST_ERROR
  } state_t;

  state_t              r_state, w_state_nx;
  logic [DATA_W-1:0]   r_a, r_b, r_res, w_a_nx, w_b_nx, w_res_nx;
  logic [1:0]          r_op, w_op_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [TMO_W-1:0]    r_tmo, w_tmo_nx;
  logic                r_pend, w_pend_nx;
  logic                r_start, r_busy, r_disp_err;
  logic [DATA_W-1:0]   r_disp_val, w_disp_nx;
  logic                w_digit, w_oper, w_clear, w_eq, w_room;
  logic [DATA_W-1:0]   w_acc_a, w_acc_b;

  // Key decode; a key in the same cycle as equal wins
  assign w_digit = key_en && (key_code <= 4'd9);
  assign w_oper  = key_en && (key_code >= 4'hA) && (key_code <= 4'hD);
  assign w_clear = key_en && (key_code == 4'hE);
  assign w_eq    = equal && !key_en;
  assign w_room  = r_cnt < CNT_W'(MAX_DIGITS);
  assign w_acc_a = DATA_W'(r_a * DATA_W'(10)) + DATA_W'(key_code);
  assign w_acc_b = DATA_W'(r_b * DATA_W'(10)) + DATA_W'(key_code);

  // Next-state and datapath update
  always_comb begin
    w_state_nx = r_state;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_res_nx   = r_res;
    w_op_nx    = r_op;
    w_cnt_nx   = r_cnt;
    w_tmo_nx   = r_tmo;
    w_pend_nx  = r_pend;
    case (r_state)
      ST_ENTER_A, ST_ENTER_B, ST_SHOW, ST_ERROR: begin
        if (w_clear) begin
          w_state_nx = ST_ENTER_A;
          w_a_nx     = '0;
          w_b_nx     = '0;
          w_cnt_nx   = '0;
          w_pend_nx  = 1'b0;
        end else if (r_state == ST_ENTER_A) begin
          if (w_digit && w_room) begin
            w_a_nx   = w_acc_a;
            w_cnt_nx = r_cnt + CNT_W'(1);
          end else if (w_oper) begin
            w_op_nx    = 2'(key_code - 4'hA);
            w_b_nx     = '0;
            w_cnt_nx   = '0;
            w_state_nx = ST_ENTER_B;
          end
        end else if (r_state == ST_ENTER_B) begin
          if (w_digit && w_room) begin
            w_b_nx   = w_acc_b;
            w_cnt_nx = r_cnt + CNT_W'(1);
          end else if (w_oper) begin
            w_op_nx = 2'(key_code - 4'hA);
          end else if (w_eq && (r_cnt != '0)) begin
            w_tmo_nx   = '0;
            w_state_nx = ((r_op == 2'd3) && (r_b == '0)) ? ST_ERROR : ST_ISSUE;
          end
        end else if (w_digit) begin
          w_a_nx     = DATA_W'(key_code);
          w_b_nx     = '0;
          w_cnt_nx   = CNT_W'(1);
          w_state_nx = ST_ENTER_A;
        end
`ifdef CALC_CHAIN_EN
        else if (w_oper && (r_state == ST_SHOW)) begin
          w_a_nx     = r_res;
          w_op_nx    = 2'(key_code - 4'hA);
          w_b_nx     = '0;
          w_cnt_nx   = '0;
          w_state_nx = ST_ENTER_B;
        end
`endif
      end
      ST_ISSUE: begin
        w_pend_nx  = r_pend || w_clear;
        w_tmo_nx   = '0;
        w_state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        w_pend_nx = r_pend || w_clear;
        if (alu_done || (r_tmo == TMO_W'(ALU_TIMEOUT - 1))) begin
          if (w_pend_nx) begin
            w_state_nx = ST_ENTER_A;
            w_a_nx     = '0;
            w_b_nx     = '0;
            w_cnt_nx   = '0;
            w_pend_nx  = 1'b0;
          end else if (alu_done && !alu_err) begin
            w_res_nx   = alu_result;
            w_state_nx = ST_SHOW;
          end else begin
            w_state_nx = ST_ERROR;
          end
        end else begin
          w_tmo_nx = r_tmo + TMO_W'(1);
        end
      end
      default: w_state_nx = ST_ENTER_A;
    endcase
  end

  // Display value follows the state being entered
  always_comb begin
    w_disp_nx = '0;
    case (w_state_nx)
      ST_ENTER_A:         w_disp_nx = w_a_nx;
      ST_ENTER_B:         w_disp_nx = (w_cnt_nx != '0) ? w_b_nx : w_a_nx;
      ST_ISSUE, ST_WAIT:  w_disp_nx = w_b_nx;
      ST_SHOW:            w_disp_nx = w_res_nx;
      default:            w_disp_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_ENTER_A;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_op       <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_pend     <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_disp_val <= '0;
      r_disp_err <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_a        <= w_a_nx;
      r_b        <= w_b_nx;
      r_res      <= w_res_nx;
      r_op       <= w_op_nx;
      r_cnt      <= w_cnt_nx;
      r_tmo      <= w_tmo_nx;
      r_pend     <= w_pend_nx;
      r_start    <= (w_state_nx == ST_ISSUE);
      r_busy     <= (w_state_nx == ST_WAIT);
      r_disp_val <= w_disp_nx;
      r_disp_err <= (w_state_nx == ST_ERROR);
    end
  end

  assign alu_start = r_start;
  assign alu_op    = r_op;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign busy      = r_busy;
  assign disp_val  = r_disp_val;
  assign disp_err  = r_disp_err;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed self-checking bench for calc_seq_ctrl.
module tb_calc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_en = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        equal = 1'b0;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'd0;
  logic        alu_err = 1'b0;
  logic [15:0] disp_val;
  logic        disp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int nb, ns;

  calc_seq_ctrl dut (
    .clk(clk), .rst(rst), .key_en(key_en), .key_code(key_code), .equal(equal),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .disp_val(disp_val), .disp_err(disp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic press(input logic [3:0] k);
    @(negedge clk); key_en = 1'b1; key_code = k;
    @(negedge clk); key_en = 1'b0;
  endtask

  task automatic pulse_eq();
    @(negedge clk); equal = 1'b1;
    @(negedge clk); equal = 1'b0;
  endtask

  // Answers the handshake after lat busy cycles (lat 0: never); returns busy and start counts
  task automatic run_alu(input int lat, input logic [15:0] res, input logic err,
                         output int n_busy, output int n_start);
    n_busy = 0; n_start = 0;
    alu_result = res; alu_err = err;
    for (int i = 0; i < 150; i++) begin
      if (busy) n_busy++;
      n_start += int'(alu_start);
      alu_done = (lat > 0) && busy && (n_busy == lat);
      if (!busy && n_busy > 0) break;
      @(negedge clk);
    end
    alu_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (alu_start !== 1'b0 || busy !== 1'b0 || alu_op !== 2'd0) begin errors++; $display("FAIL reset_ctrl start=%b busy=%b op=%0d exp 0", alu_start, busy, alu_op); end
    checks++; if (alu_a !== 16'd0 || alu_b !== 16'd0 || disp_val !== 16'd0 || disp_err !== 1'b0) begin errors++; $display("FAIL reset_data a=%0d b=%0d disp=%0d err=%b exp 0", alu_a, alu_b, disp_val, disp_err); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    press(4'd1); press(4'd2);
    checks++; if (disp_val !== 16'd12) begin errors++; $display("FAIL add_disp_a got=%0d exp=12", disp_val); end
    press(4'hA);
    checks++; if (disp_val !== 16'd12) begin errors++; $display("FAIL add_disp_after_op got=%0d exp=12", disp_val); end
    press(4'd3);
    checks++; if (disp_val !== 16'd3) begin errors++; $display("FAIL add_disp_b got=%0d exp=3", disp_val); end
    pulse_eq();
    checks++; if (alu_start !== 1'b1 || alu_op !== 2'd0 || alu_a !== 16'd12 || alu_b !== 16'd3) begin errors++; $display("FAIL add_issue start=%b op=%0d a=%0d b=%0d exp 1/0/12/3", alu_start, alu_op, alu_a, alu_b); end
    run_alu(5, 16'd15, 1'b0, nb, ns);
    checks++; if (nb !== 5 || ns !== 1) begin errors++; $display("FAIL add_handshake busy=%0d starts=%0d exp 5/1", nb, ns); end
    checks++; if (disp_val !== 16'd15 || disp_err !== 1'b0) begin errors++; $display("FAIL add_result disp=%0d err=%b exp 15/0", disp_val, disp_err); end
  endtask

  task automatic test_digits();
    press(4'hE);
    checks++; if (disp_val !== 16'd0) begin errors++; $display("FAIL digits_clear got=%0d exp=0", disp_val); end
    press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5);
    checks++; if (disp_val !== 16'd9876) begin errors++; $display("FAIL digits_max got=%0d exp=9876", disp_val); end
  endtask

  task automatic test_div0();
    press(4'hE); press(4'd7); press(4'hD); press(4'd0);
    pulse_eq();
    checks++; if (alu_start !== 1'b0 || disp_err !== 1'b1 || disp_val !== 16'd0) begin errors++; $display("FAIL div0_error start=%b err=%b disp=%0d exp 0/1/0", alu_start, disp_err, disp_val); end
    @(negedge clk);
    checks++; if (alu_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL div0_nostart start=%b busy=%b exp 0/0", alu_start, busy); end
    press(4'd4);
    checks++; if (disp_err !== 1'b0 || disp_val !== 16'd4) begin errors++; $display("FAIL div0_recover err=%b disp=%0d exp 0/4", disp_err, disp_val); end
  endtask

  task automatic test_timeout();
    press(4'hA); press(4'd2);
    pulse_eq();
    run_alu(0, 16'd0, 1'b0, nb, ns);
    checks++; if (nb !== 64 || busy !== 1'b0 || disp_err !== 1'b1) begin errors++; $display("FAIL timeout busy_cycles=%0d busy=%b err=%b exp 64/0/1", nb, busy, disp_err); end
    @(negedge clk); alu_result = 16'd77; alu_done = 1'b1;
    @(negedge clk); alu_done = 1'b0;
    @(negedge clk);
    checks++; if (disp_err !== 1'b1 || disp_val !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_late_done err=%b disp=%0d busy=%b exp 1/0/0", disp_err, disp_val, busy); end
  endtask

  task automatic test_clear_wait();
    press(4'hE); press(4'd5); press(4'hA); press(4'd1);
    pulse_eq();
    @(negedge clk);
    press(4'hE);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clrwait_busy got=%b exp=1", busy); end
    run_alu(3, 16'd99, 1'b0, nb, ns);
    checks++; if (disp_val !== 16'd0 || disp_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clrwait_discard disp=%0d err=%b busy=%b exp 0/0/0", disp_val, disp_err, busy); end
    press(4'd3);
    checks++; if (disp_val !== 16'd3) begin errors++; $display("FAIL clrwait_enter_a got=%0d exp=3", disp_val); end
  endtask

  task automatic test_edge_keys();
    press(4'hE); press(4'd3); press(4'hA);
    pulse_eq();
    checks++; if (alu_start !== 1'b0 || disp_val !== 16'd3) begin errors++; $display("FAIL eq_no_digits start=%b disp=%0d exp 0/3", alu_start, disp_val); end
    press(4'd2);
    @(negedge clk); key_en = 1'b1; key_code = 4'hF; equal = 1'b1;
    @(negedge clk); key_en = 1'b0; equal = 1'b0;
    @(negedge clk);
    checks++; if (alu_start !== 1'b0 || busy !== 1'b0 || disp_val !== 16'd2) begin errors++; $display("FAIL key_and_equal start=%b busy=%b disp=%0d exp 0/0/2", alu_start, busy, disp_val); end
    alu_result = 16'd55; alu_done = 1'b1;
    @(negedge clk); alu_done = 1'b0;
    @(negedge clk);
    checks++; if (disp_val !== 16'd2 || disp_err !== 1'b0) begin errors++; $display("FAIL stray_done disp=%0d err=%b exp 2/0", disp_val, disp_err); end
  endtask

  task automatic test_reset_mid_op();
    press(4'hE); press(4'd1); press(4'hA); press(4'd1);
    pulse_eq();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || alu_start !== 1'b0 || disp_val !== 16'd0) begin errors++; $display("FAIL reset_mid busy=%b start=%b disp=%0d exp 0/0/0", busy, alu_start, disp_val); end
    @(negedge clk); rst = 1'b0;
    alu_result = 16'd2; alu_done = 1'b1;
    @(negedge clk); alu_done = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || disp_val !== 16'd0 || disp_err !== 1'b0) begin errors++; $display("FAIL reset_late_done busy=%b disp=%0d err=%b exp 0/0/0", busy, disp_val, disp_err); end
  endtask

  task automatic test_chain();
    press(4'hE); press(4'd5); press(4'hC); press(4'd4);
    pulse_eq();
    checks++; if (alu_op !== 2'd2 || alu_a !== 16'd5 || alu_b !== 16'd4) begin errors++; $display("FAIL chain_mul op=%0d a=%0d b=%0d exp 2/5/4", alu_op, alu_a, alu_b); end
    run_alu(2, 16'd20, 1'b0, nb, ns);
    checks++; if (disp_val !== 16'd20) begin errors++; $display("FAIL chain_result got=%0d exp=20", disp_val); end
    press(4'hB);
`ifdef CALC_CHAIN_EN
    press(4'd6);
    pulse_eq();
    checks++; if (alu_start !== 1'b1 || alu_a !== 16'd20 || alu_b !== 16'd6 || alu_op !== 2'd1) begin errors++; $display("FAIL chain_second start=%b a=%0d b=%0d op=%0d exp 1/20/6/1", alu_start, alu_a, alu_b, alu_op); end
    run_alu(2, 16'd14, 1'b0, nb, ns);
    checks++; if (disp_val !== 16'd14) begin errors++; $display("FAIL chain_second_result got=%0d exp=14", disp_val); end
`else
    checks++; if (disp_val !== 16'd20 || disp_err !== 1'b0) begin errors++; $display("FAIL chain_op_ignored disp=%0d err=%b exp 20/0", disp_val, disp_err); end
    press(4'd6);
    checks++; if (disp_val !== 16'd6) begin errors++; $display("FAIL chain_new_a got=%0d exp=6", disp_val); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_digits();
    test_div0();
    test_timeout();
    test_clear_wait();
    test_edge_keys();
    test_reset_mid_op();
    test_chain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
